// File: rtl/dense_layer_seq_if.sv
// Handshake and data bundle for one dense layer: vector in, result out, plus status.
// Master drives the vector and out_ready; the layer (slave) drives result and status.
interface dense_layer_seq_if #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int OUT_W = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic [N_IN*WIDTH-1:0]       x_flat;
  logic [N_OUT*N_IN*WIDTH-1:0] w_flat;
  logic [N_OUT*WIDTH-1:0]      b_flat;
  logic [1:0]                  act_mode;
  logic                        out_valid;
  logic                        out_ready;
  logic [N_OUT*OUT_W-1:0]      y_flat;
  logic                        sat;
  logic                        busy;

  modport master (
    output in_valid, x_flat, w_flat, b_flat, act_mode, out_ready,
    input  in_ready, out_valid, y_flat, sat, busy
  );

  modport slave (
    input  in_valid, x_flat, w_flat, b_flat, act_mode, out_ready,
    output in_ready, out_valid, y_flat, sat, busy
  );
endinterface

// File: rtl/dense_layer_seq.sv
// Fully-connected layer y = act(W*x + b) computed with a single time-shared signed MAC.
// Result is clamped to OUT_W bits; sat flags any clamped neuron of the current result.
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready high
// MAC   | one product per cycle, neuron by neuron, y written at each neuron end
// DONE  | out_valid high, result held until out_ready
module dense_layer_seq #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int OUT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  dense_layer_seq_if.slave bus
);
  localparam int ACC_W = 2*WIDTH + $clog2(N_IN+1);
  localparam int P_W   = 2*WIDTH;
  localparam int I_W   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int J_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [I_W-1:0] I_LAST = I_W'(N_IN-1);
  localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT-1);
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                  state;
  logic [I_W-1:0]          i_cnt;
  logic [J_W-1:0]          j_cnt;
  logic [J_W-1:0]          j_next;
  logic signed [ACC_W-1:0] acc;
  logic [N_IN*WIDTH-1:0]   x_reg;
  logic [1:0]              mode_reg;
  logic [N_OUT*OUT_W-1:0]  y_reg;
  logic                    sat_reg;
  logic                    out_valid_reg;
  logic                    busy_reg;

  logic signed [WIDTH-1:0] x_sel;
  logic signed [WIDTH-1:0] w_sel;
  logic signed [WIDTH-1:0] b_first;
  logic signed [WIDTH-1:0] b_next;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] act_val;
  logic [OUT_W-1:0]        y_new;
  logic                    clamp;

  assign j_next  = (j_cnt == J_LAST) ? '0 : j_cnt + 1'b1;
  assign b_first = bus.b_flat[WIDTH-1:0];

  // Mux loops keep every select a constant slice, whatever N_IN/N_OUT are.
  always_comb begin
    x_sel  = '0;
    w_sel  = '0;
    b_next = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (i_cnt == I_W'(k)) begin
        x_sel = x_reg[k*WIDTH +: WIDTH];
        for (int m = 0; m < N_OUT; m++)
          if (j_cnt == J_W'(m)) w_sel = bus.w_flat[(m*N_IN+k)*WIDTH +: WIDTH];
      end
    end
    for (int m = 0; m < N_OUT; m++)
      if (j_next == J_W'(m)) b_next = bus.b_flat[m*WIDTH +: WIDTH];
  end

  assign prod = P_W'(x_sel) * P_W'(w_sel);
  assign sum  = acc + ACC_W'(prod);

  always_comb begin
    case (mode_reg)
      2'd1:    act_val = sum[ACC_W-1] ? '0 : sum;
      2'd2:    act_val = sum[ACC_W-1] ? (sum >>> 3) : sum;
      default: act_val = sum;
    endcase
  end

  always_comb begin
    clamp = 1'b0;
    y_new = act_val[OUT_W-1:0];
    if (act_val > Y_MAX) begin
      clamp = 1'b1;
      y_new = Y_MAX[OUT_W-1:0];
    end else if (act_val < Y_MIN) begin
      clamp = 1'b1;
      y_new = Y_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      i_cnt         <= '0;
      j_cnt         <= '0;
      acc           <= '0;
      x_reg         <= '0;
      mode_reg      <= '0;
      y_reg         <= '0;
      sat_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_reg    <= bus.x_flat;
            mode_reg <= bus.act_mode;
            i_cnt    <= '0;
            j_cnt    <= '0;
            acc      <= ACC_W'(b_first);
            sat_reg  <= 1'b0;
            busy_reg <= 1'b1;
            state    <= MAC;
          end
        end
        MAC: begin
          if (i_cnt != I_LAST) begin
            acc   <= sum;
            i_cnt <= i_cnt + 1'b1;
          end else begin
            for (int m = 0; m < N_OUT; m++)
              if (j_cnt == J_W'(m)) y_reg[m*OUT_W +: OUT_W] <= y_new;
            sat_reg <= sat_reg | clamp;
            acc     <= ACC_W'(b_next);
            i_cnt   <= '0;
            j_cnt   <= j_next;
            if (j_cnt == J_LAST) begin
              out_valid_reg <= 1'b1;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.y_flat    = y_reg;
  assign bus.sat       = sat_reg;
  assign bus.busy      = busy_reg;
endmodule
